// File: rtl/core_mem_arbiter_if.sv
// Bus bundle between the CPU fetch/data ports, the arbiter and the single memory port.
//   master : arbiter view (takes I/D requests and memory responses, drives acks and the memory request)
//   slave  : environment view (CPU requestors and memory model)
interface core_mem_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);
  // Instruction fetch side
  logic          i_req_val;
  logic [AW-1:0] i_req_addr;
  logic          i_req_ack;
  logic [DW-1:0] i_ack_rdata;

  // Data side
  logic          d_req_val;
  logic [AW-1:0] d_req_addr;
  logic [2:0]    d_req_cop;
  logic [DW-1:0] d_req_wdata;
  logic [2:0]    d_req_size;
  logic          d_req_ack;
  logic [DW-1:0] d_ack_rdata;

  // Memory side
  logic          mem_req_val;
  logic [AW-1:0] mem_req_addr;
  logic [2:0]    mem_req_cop;
  logic [DW-1:0] mem_req_wdata;
  logic [2:0]    mem_req_size;
  logic          mem_req_ack;
  logic [DW-1:0] mem_ack_rdata;
  logic          mem_timeout_err;

  modport master (
    input  i_req_val, i_req_addr,
    output i_req_ack, i_ack_rdata,
    input  d_req_val, d_req_addr, d_req_cop, d_req_wdata, d_req_size,
    output d_req_ack, d_ack_rdata,
    output mem_req_val, mem_req_addr, mem_req_cop, mem_req_wdata, mem_req_size,
    input  mem_req_ack, mem_ack_rdata,
    output mem_timeout_err
  );

  modport slave (
    output i_req_val, i_req_addr,
    input  i_req_ack, i_ack_rdata,
    output d_req_val, d_req_addr, d_req_cop, d_req_wdata, d_req_size,
    input  d_req_ack, d_ack_rdata,
    input  mem_req_val, mem_req_addr, mem_req_cop, mem_req_wdata, mem_req_size,
    output mem_req_ack, mem_ack_rdata,
    input  mem_timeout_err
  );
endinterface

// File: rtl/core_mem_arbiter.sv
// Arbitrates CPU instruction and data requests onto a single memory port with one
// transaction in flight, routes the response back to the issuing side, and forces
// completion (ERR_DATA + mem_timeout_err) when memory never acknowledges.
// Ports:
//   clk    core clock
//   rst_n  asynchronous reset, active low; drops any in-flight transaction silently
//   bus    core_mem_arbiter_if.master (I/D request+ack channels, memory request/response)
module core_mem_arbiter #(
  parameter int unsigned   AW       = 32,
  parameter int unsigned   DW       = 32,
  parameter int unsigned   TIMEOUT  = 255,
  parameter logic [DW-1:0] ERR_DATA = DW'(32'hDEAD_BEEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  core_mem_arbiter_if.master bus
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  // Counter value seen on the last BUSY cycle allowed before forced completion
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [2:0] COP_READ  = 3'b000;
  localparam logic [2:0] SIZE_WORD = 3'b010;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t        state;
  logic          owner_d;    // 1: data side owns the in-flight transaction
  logic          last_d;     // 1: last grant went to the data side
  logic [CW-1:0] wd_cnt;

  logic          mem_val_q;
  logic [AW-1:0] mem_addr_q;
  logic [2:0]    mem_cop_q;
  logic [DW-1:0] mem_wdata_q;
  logic [2:0]    mem_size_q;
  logic          err_q;
  logic          i_ack_q;
  logic          d_ack_q;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;

  logic grant_d_c;
  logic wd_fire_c;

  // Data side wins when it is the only requester, or when both request and I went last
  assign grant_d_c = bus.d_req_val && (!bus.i_req_val || !last_d);
  assign wd_fire_c = (TIMEOUT != 0) && (wd_cnt == WD_LAST);

  // Arbiter FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner_d     <= 1'b0;
      last_d      <= 1'b0;
      wd_cnt      <= '0;
      mem_val_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_cop_q   <= '0;
      mem_wdata_q <= '0;
      mem_size_q  <= '0;
      err_q       <= 1'b0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_req_val || bus.d_req_val) begin
            state     <= BUSY;
            mem_val_q <= 1'b1;
            wd_cnt    <= '0;
            owner_d   <= grant_d_c;
            last_d    <= grant_d_c;
            if (grant_d_c) begin
              mem_addr_q  <= bus.d_req_addr;
              mem_cop_q   <= bus.d_req_cop;
              mem_wdata_q <= bus.d_req_wdata;
              mem_size_q  <= bus.d_req_size;
            end else begin
              mem_addr_q  <= bus.i_req_addr;
              mem_cop_q   <= COP_READ;
              mem_wdata_q <= '0;
              mem_size_q  <= SIZE_WORD;
            end
          end
        end
        BUSY: begin
          // A real ack beats a timeout landing in the same cycle
          if (bus.mem_req_ack) begin
            state     <= RESP;
            mem_val_q <= 1'b0;
            if (owner_d) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= bus.mem_ack_rdata;
            end else begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= bus.mem_ack_rdata;
            end
          end else if (wd_fire_c) begin
            state     <= RESP;
            mem_val_q <= 1'b0;
            err_q     <= 1'b1;
            if (owner_d) begin
              d_ack_q   <= 1'b1;
              d_rdata_q <= ERR_DATA;
            end else begin
              i_ack_q   <= 1'b1;
              i_rdata_q <= ERR_DATA;
            end
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        RESP: begin
          // Requests seen during the ack cycle belong to the finished transaction
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req_val     = mem_val_q;
  assign bus.mem_req_addr    = mem_addr_q;
  assign bus.mem_req_cop     = mem_cop_q;
  assign bus.mem_req_wdata   = mem_wdata_q;
  assign bus.mem_req_size    = mem_size_q;
  assign bus.mem_timeout_err = err_q;
  assign bus.i_req_ack       = i_ack_q;
  assign bus.i_ack_rdata     = i_rdata_q;
  assign bus.d_req_ack       = d_ack_q;
  assign bus.d_ack_rdata     = d_rdata_q;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Directed self-checking bench for core_mem_arbiter: a default-timeout instance for
// functional scenarios and a TIMEOUT=4 instance for watchdog scenarios.
module tb_core_mem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   i_ack_cnt;
  int   mem_rise_cnt;
  bit   prev_val;

  core_mem_arbiter_if #(.AW(32), .DW(32)) bus ();
  core_mem_arbiter_if #(.AW(32), .DW(32)) bus_to ();

  core_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  core_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut_to (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Event counters on the main instance
  always @(posedge clk) begin
    if (bus.i_req_ack) i_ack_cnt++;
    if (bus.mem_req_val && !prev_val) mem_rise_cnt++;
    prev_val = bus.mem_req_val;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.i_req_val = 0; bus.i_req_addr = '0;
    bus.d_req_val = 0; bus.d_req_addr = '0; bus.d_req_cop = '0; bus.d_req_wdata = '0; bus.d_req_size = '0;
    bus.mem_req_ack = 0; bus.mem_ack_rdata = '0;
    bus_to.i_req_val = 0; bus_to.i_req_addr = '0;
    bus_to.d_req_val = 0; bus_to.d_req_addr = '0; bus_to.d_req_cop = '0; bus_to.d_req_wdata = '0; bus_to.d_req_size = '0;
    bus_to.mem_req_ack = 0; bus_to.mem_ack_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  // Bounded wait for the main instance to raise mem_req_val
  task automatic wait_mem_val(output bit ok);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      if (bus.mem_req_val) begin
        ok = 1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.mem_req_val !== 1'b0) begin failures++; $display("FAIL reset_mem_val: got %b expected 0", bus.mem_req_val); end
    checks++; if (bus.mem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_req_addr); end
    checks++; if ({bus.i_req_ack, bus.d_req_ack, bus.mem_timeout_err} !== 3'b000) begin failures++; $display("FAIL reset_acks: got %b expected 000", {bus.i_req_ack, bus.d_req_ack, bus.mem_timeout_err}); end
    checks++; if ({bus.i_ack_rdata, bus.d_ack_rdata} !== 64'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", {bus.i_ack_rdata, bus.d_ack_rdata}); end
  endtask

  task automatic test_alternate();
    logic [31:0] exp_addr;
    bit ok;
    do_reset();
    bus.i_req_val = 1; bus.i_req_addr = 32'h400;
    bus.d_req_val = 1; bus.d_req_addr = 32'h800; bus.d_req_cop = 3'b000; bus.d_req_size = 3'b010;
    for (int k = 0; k < 4; k++) begin
      exp_addr = (k % 2 == 0) ? 32'h800 : 32'h400;
      wait_mem_val(ok);
      checks++; if (!ok) begin failures++; $display("FAIL alt_wait_val%0d: got timeout expected mem_req_val", k); end
      checks++; if (bus.mem_req_addr !== exp_addr) begin failures++; $display("FAIL alt_addr%0d: got %h expected %h", k, bus.mem_req_addr, exp_addr); end
      bus.mem_req_ack = 1; bus.mem_ack_rdata = 32'h50 + 32'(k);
      tick();
      bus.mem_req_ack = 0;
      if (k % 2 == 0) begin
        checks++; if ({bus.d_req_ack, bus.i_req_ack} !== 2'b10) begin failures++; $display("FAIL alt_ack%0d: got d/i=%b expected 10", k, {bus.d_req_ack, bus.i_req_ack}); end
        checks++; if (bus.d_ack_rdata !== 32'h50 + 32'(k)) begin failures++; $display("FAIL alt_rdata%0d: got %h expected %h", k, bus.d_ack_rdata, 32'h50 + 32'(k)); end
      end else begin
        checks++; if ({bus.d_req_ack, bus.i_req_ack} !== 2'b01) begin failures++; $display("FAIL alt_ack%0d: got d/i=%b expected 01", k, {bus.d_req_ack, bus.i_req_ack}); end
        checks++; if (bus.i_ack_rdata !== 32'h50 + 32'(k)) begin failures++; $display("FAIL alt_rdata%0d: got %h expected %h", k, bus.i_ack_rdata, 32'h50 + 32'(k)); end
      end
      if (k == 3) begin
        bus.i_req_val = 0; bus.d_req_val = 0;
      end
      tick();
    end
    tick(); tick();
  endtask

  task automatic test_i_only();
    bus.i_req_val = 1; bus.i_req_addr = 32'h100;
    tick();
    checks++; if (bus.mem_req_val !== 1'b1) begin failures++; $display("FAIL ionly_val: got %b expected 1", bus.mem_req_val); end
    checks++; if ({bus.mem_req_addr, bus.mem_req_cop, bus.mem_req_size, bus.mem_req_wdata} !== {32'h100, 3'b000, 3'b010, 32'h0}) begin
      failures++; $display("FAIL ionly_fields: got addr=%h cop=%b size=%b wdata=%h expected 100/000/010/0", bus.mem_req_addr, bus.mem_req_cop, bus.mem_req_size, bus.mem_req_wdata);
    end
    tick();
    bus.mem_req_ack = 1; bus.mem_ack_rdata = 32'h13;
    tick();
    bus.mem_req_ack = 0;
    checks++; if ({bus.i_req_ack, bus.d_req_ack} !== 2'b10) begin failures++; $display("FAIL ionly_ack: got i/d=%b expected 10", {bus.i_req_ack, bus.d_req_ack}); end
    checks++; if (bus.i_ack_rdata !== 32'h13) begin failures++; $display("FAIL ionly_rdata: got %h expected 00000013", bus.i_ack_rdata); end
    checks++; if (bus.mem_req_val !== 1'b0) begin failures++; $display("FAIL ionly_val_drop: got %b expected 0", bus.mem_req_val); end
    bus.i_req_val = 0;
    tick();
    checks++; if ({bus.i_req_ack, bus.d_req_ack} !== 2'b00) begin failures++; $display("FAIL ionly_ack_pulse: got i/d=%b expected 00", {bus.i_req_ack, bus.d_req_ack}); end
    checks++; if (bus.i_ack_rdata !== 32'h13) begin failures++; $display("FAIL ionly_rdata_hold: got %h expected 00000013", bus.i_ack_rdata); end
    tick();
  endtask

  task automatic test_d_write();
    bit ok;
    bus.d_req_val = 1; bus.d_req_addr = 32'h2000; bus.d_req_cop = 3'b001; bus.d_req_wdata = 32'hCAFE_F00D; bus.d_req_size = 3'b000;
    wait_mem_val(ok);
    checks++; if (!ok) begin failures++; $display("FAIL dwr_wait_val: got timeout expected mem_req_val"); end
    for (int w = 0; w < 6; w++) begin
      checks++; if ({bus.mem_req_val, bus.mem_req_addr, bus.mem_req_cop, bus.mem_req_wdata, bus.mem_req_size} !== {1'b1, 32'h2000, 3'b001, 32'hCAFE_F00D, 3'b000}) begin
        failures++; $display("FAIL dwr_fields%0d: got val=%b addr=%h cop=%b wdata=%h size=%b expected 1/2000/001/cafef00d/000", w, bus.mem_req_val, bus.mem_req_addr, bus.mem_req_cop, bus.mem_req_wdata, bus.mem_req_size);
      end
      if (w < 5) tick();
    end
    bus.mem_req_ack = 1; bus.mem_ack_rdata = 32'h55;
    tick();
    bus.mem_req_ack = 0;
    checks++; if ({bus.d_req_ack, bus.i_req_ack} !== 2'b10) begin failures++; $display("FAIL dwr_ack: got d/i=%b expected 10", {bus.d_req_ack, bus.i_req_ack}); end
    checks++; if (bus.d_ack_rdata !== 32'h55) begin failures++; $display("FAIL dwr_rdata: got %h expected 00000055", bus.d_ack_rdata); end
    bus.d_req_val = 0;
    tick();
    checks++; if (bus.d_req_ack !== 1'b0) begin failures++; $display("FAIL dwr_ack_pulse: got %b expected 0", bus.d_req_ack); end
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    i_ack_cnt = 0;
    mem_rise_cnt = 0;
    bus.i_req_val = 1; bus.i_req_addr = 32'h1000;
    for (int k = 0; k < 3; k++) begin
      wait_mem_val(ok);
      checks++; if (!ok) begin failures++; $display("FAIL b2b_wait_val%0d: got timeout expected mem_req_val", k); end
      checks++; if (bus.mem_req_addr !== 32'h1000 + 32'(4 * k)) begin failures++; $display("FAIL b2b_addr%0d: got %h expected %h", k, bus.mem_req_addr, 32'h1000 + 32'(4 * k)); end
      bus.mem_req_ack = 1; bus.mem_ack_rdata = 32'hA0 + 32'(k);
      tick();
      bus.mem_req_ack = 0;
      checks++; if (bus.i_ack_rdata !== 32'hA0 + 32'(k)) begin failures++; $display("FAIL b2b_rdata%0d: got %h expected %h", k, bus.i_ack_rdata, 32'hA0 + 32'(k)); end
      if (k == 2) bus.i_req_val = 0;
      else bus.i_req_addr = 32'h1000 + 32'(4 * (k + 1));
      tick();
      checks++; if ({bus.i_req_ack, bus.mem_req_val} !== 2'b00) begin failures++; $display("FAIL b2b_gap%0d: got ack/val=%b expected 00", k, {bus.i_req_ack, bus.mem_req_val}); end
    end
    tick(); tick(); tick();
    checks++; if (i_ack_cnt !== 3) begin failures++; $display("FAIL b2b_ack_count: got %0d expected 3", i_ack_cnt); end
    checks++; if (mem_rise_cnt !== 3) begin failures++; $display("FAIL b2b_mem_req_count: got %0d expected 3", mem_rise_cnt); end
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    bus.i_req_val = 1; bus.i_req_addr = 32'h300;
    wait_mem_val(ok);
    checks++; if (!ok) begin failures++; $display("FAIL rst_busy_wait_val: got timeout expected mem_req_val"); end
    tick();
    rst_n = 0;
    bus.i_req_val = 0;
    #1;
    checks++; if ({bus.mem_req_val, bus.i_req_ack, bus.d_req_ack, bus.mem_timeout_err} !== 4'b0000) begin failures++; $display("FAIL rst_busy_ctrl: got %b expected 0000", {bus.mem_req_val, bus.i_req_ack, bus.d_req_ack, bus.mem_timeout_err}); end
    checks++; if ({bus.mem_req_addr, bus.i_ack_rdata, bus.d_ack_rdata} !== 96'h0) begin failures++; $display("FAIL rst_busy_data: got %h expected 0", {bus.mem_req_addr, bus.i_ack_rdata, bus.d_ack_rdata}); end
    tick();
    rst_n = 1;
    tick();
    bus.mem_req_ack = 1; bus.mem_ack_rdata = 32'h77;
    tick();
    bus.mem_req_ack = 0;
    for (int n = 0; n < 3; n++) begin
      checks++; if ({bus.i_req_ack, bus.d_req_ack, bus.mem_req_val} !== 3'b000) begin failures++; $display("FAIL rst_late_ack%0d: got i/d/val=%b expected 000", n, {bus.i_req_ack, bus.d_req_ack, bus.mem_req_val}); end
      tick();
    end
  endtask

  task automatic test_timeout();
    bus_to.i_req_val = 1; bus_to.i_req_addr = 32'h40;
    tick();
    for (int n = 0; n < 4; n++) begin
      checks++; if (bus_to.mem_req_val !== 1'b1) begin failures++; $display("FAIL to_val_busy%0d: got %b expected 1", n, bus_to.mem_req_val); end
      tick();
    end
    checks++; if (bus_to.mem_req_val !== 1'b0) begin failures++; $display("FAIL to_val_drop: got %b expected 0", bus_to.mem_req_val); end
    checks++; if ({bus_to.i_req_ack, bus_to.d_req_ack, bus_to.mem_timeout_err} !== 3'b101) begin failures++; $display("FAIL to_ack_err: got i/d/err=%b expected 101", {bus_to.i_req_ack, bus_to.d_req_ack, bus_to.mem_timeout_err}); end
    checks++; if (bus_to.i_ack_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL to_rdata: got %h expected deadbeef", bus_to.i_ack_rdata); end
    bus_to.i_req_val = 0;
    tick();
    checks++; if ({bus_to.i_req_ack, bus_to.mem_timeout_err} !== 2'b00) begin failures++; $display("FAIL to_pulse: got ack/err=%b expected 00", {bus_to.i_req_ack, bus_to.mem_timeout_err}); end
    tick();
  endtask

  task automatic test_timeout_ack_wins();
    bus_to.d_req_val = 1; bus_to.d_req_addr = 32'h80; bus_to.d_req_cop = 3'b000; bus_to.d_req_size = 3'b010;
    tick();
    tick(); tick(); tick();
    checks++; if (bus_to.mem_req_val !== 1'b1) begin failures++; $display("FAIL race_val_last: got %b expected 1", bus_to.mem_req_val); end
    bus_to.mem_req_ack = 1; bus_to.mem_ack_rdata = 32'h99;
    tick();
    bus_to.mem_req_ack = 0;
    checks++; if ({bus_to.d_req_ack, bus_to.i_req_ack, bus_to.mem_timeout_err} !== 3'b100) begin failures++; $display("FAIL race_ack_err: got d/i/err=%b expected 100", {bus_to.d_req_ack, bus_to.i_req_ack, bus_to.mem_timeout_err}); end
    checks++; if (bus_to.d_ack_rdata !== 32'h99) begin failures++; $display("FAIL race_rdata: got %h expected 00000099", bus_to.d_ack_rdata); end
    bus_to.d_req_val = 0;
    tick(); tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    i_ack_cnt = 0;
    mem_rise_cnt = 0;
    prev_val = 0;
    rst_n = 0;
    clear_inputs();
    test_reset();
    test_alternate();
    test_i_only();
    test_d_write();
    test_back_to_back();
    test_reset_mid_busy();
    test_timeout();
    test_timeout_ack_wins();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
